// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with 16x oversampling.
//
// Receives idle-high, start-0, 8 data bits LSB first, stop-1 frames from the
// pad/loopback wire. Each received byte is handed over on a valid/ready
// handshake. Framing errors and overruns are flagged.
//
// Parameters
//   TICK_DIV  clk cycles per oversample tick (>= 2)
//   OS_RATE   oversample ticks per bit; fixed at 16, do not override
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   rx_in      in   asynchronous serial line, idle high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available; held until accepted
//   rx_ready   in   consumer accepts when rx_valid & rx_ready at posedge clk
//   frame_err  out  one-clk pulse: stop bit sampled 0, byte dropped
//   overrun    out  sticky: a byte completed while rx_valid=1, byte lost
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int TICK_DIV = 326,
  parameter int OS_RATE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST     = PW'(TICK_DIV - 1);
  // Start bit is checked half a bit in; data/stop bits a full bit later.
  localparam logic [3:0]    TICK_MID_START = 4'(OS_RATE / 2 - 1);
  localparam logic [3:0]    TICK_MID_BIT   = 4'(OS_RATE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rx_meta_reg;
  logic          rx_s_reg;
  logic          armed_reg,     armed_next;
  logic [1:0]    state_reg,     state_next;
  logic [PW-1:0] presc_reg,     presc_next;
  logic [3:0]    tick_cnt_reg,  tick_cnt_next;
  logic [3:0]    bit_cnt_reg,   bit_cnt_next;
  logic [7:0]    shreg_reg,     shreg_next;
  logic [7:0]    rx_data_reg,   rx_data_next;
  logic          rx_valid_reg,  rx_valid_next;
  logic          frame_err_reg, frame_err_next;
  logic          overrun_reg,   overrun_next;

  logic tick;
  logic accept;

  // The prescaler is held at 0 in IDLE, so no tick can fire there.
  assign tick   = (state_reg != S_IDLE) && (presc_reg == PRESC_LAST);
  assign accept = rx_valid_reg & rx_ready;

  always_comb begin
    armed_next     = armed_reg;
    state_next     = state_reg;
    presc_next     = presc_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shreg_next     = shreg_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = rx_valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = overrun_reg;

    // Prescaler: aligned to the start edge by holding it at 0 while idle.
    if (state_reg == S_IDLE) begin
      presc_next = '0;
    end else if (tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + 1'b1;
    end

    if (tick) begin
      tick_cnt_next = tick_cnt_reg + 4'd1;
    end

    if (accept) begin
      rx_valid_next = 1'b0;
      overrun_next  = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (rx_s_reg) begin
          armed_next = 1'b1;
        end
        if (armed_reg && !rx_s_reg) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (tick && tick_cnt_reg == TICK_MID_START) begin
          if (rx_s_reg) begin
            state_next = S_IDLE;          // false start / glitch
          end else begin
            state_next   = S_DATA;
            bit_cnt_next = 4'd0;
          end
        end
      end

      S_DATA: begin
        if (tick && tick_cnt_reg == TICK_MID_BIT) begin
          shreg_next   = {rx_s_reg, shreg_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            state_next = S_STOP;
          end
        end
      end

      default: begin  // S_STOP
        if (tick && tick_cnt_reg == TICK_MID_BIT) begin
          if (rx_s_reg) begin
            // A same-cycle accept frees the holding register, so load wins.
            if (!rx_valid_reg || accept) begin
              rx_data_next  = shreg_reg;
              rx_valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            armed_next     = 1'b0;        // break: wait for line to go high
          end
          // Leaving at mid stop bit leaves time to catch a back-to-back start.
          state_next = S_IDLE;
        end
      end
    endcase

    if (state_next != state_reg) begin
      tick_cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg   <= 1'b1;
      rx_s_reg      <= 1'b1;
      armed_reg     <= 1'b1;
      state_reg     <= S_IDLE;
      presc_reg     <= '0;
      tick_cnt_reg  <= 4'd0;
      bit_cnt_reg   <= 4'd0;
      shreg_reg     <= 8'd0;
      rx_data_reg   <= 8'd0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_meta_reg   <= rx_in;
      rx_s_reg      <= rx_meta_reg;
      armed_reg     <= armed_next;
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shreg_reg     <= shreg_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (TICK_DIV=4, so one
// bit is 64 clk). A negedge monitor collects accepted bytes and counts
// frame_err / rx_valid cycles; the main sequence checks them after each step.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  int cyc       = 0;
  int start_cyc = 0;
  int rise_cyc  = 0;
  int fe_cnt    = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] q[$];

  int fe_base;
  int valid_base;

  uart_rx #(.TICK_DIV(4), .OS_RATE(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so negedge sees what the next posedge sees.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) q.push_back(rx_data);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < q.size()) return {24'd0, q[i]};
    return 32'hDEAD;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bclk);
    rx_in = 1'b0;
    start_cyc = cyc;
    wait_clk(bclk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      wait_clk(bclk);
    end
    rx_in = stop_bit;
    wait_clk(bclk);
  endtask

  initial begin
    reset    = 1'b0;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    wait_clk(5);

    // Reset state
    check("reset_rx_data",   {24'd0, rx_data},   32'h00);
    check("reset_rx_valid",  {31'd0, rx_valid},  32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    check("reset_overrun",   {31'd0, overrun},   32'h0);
    reset = 1'b1;
    wait_clk(BIT_CLK);

    // 1: single byte, consumer always ready
    rx_ready = 1'b1;
    q.delete();
    fe_base = fe_cnt;
    valid_base = valid_cnt;
    send_byte(8'hA5, 1'b1, BIT_CLK);
    wait_clk(16);
    $display("t1: sent 0xA5, got %0d byte(s)", q.size());
    check("t1_count",      q.size(),               32'd1);
    check("t1_data",       q_at(0),                32'hA5);
    check("t1_latency",    rise_cyc - start_cyc,   32'd611);
    check("t1_valid_clks", valid_cnt - valid_base, 32'd1);
    check("t1_frame_err",  fe_cnt - fe_base,       32'd0);
    check("t1_overrun",    {31'd0, overrun},       32'h0);

    // 2: back-to-back bytes while the consumer stalls -> overrun
    rx_ready = 1'b0;
    q.delete();
    send_byte(8'h3C, 1'b1, BIT_CLK);
    send_byte(8'hFF, 1'b1, BIT_CLK);
    wait_clk(16);
    $display("t2: sent 0x3C,0xFF stalled, rx_data=0x%0h overrun=%0b", rx_data, overrun);
    check("t2_valid_held", {31'd0, rx_valid}, 32'h1);
    check("t2_data_kept",  {24'd0, rx_data},  32'h3C);
    check("t2_overrun",    {31'd0, overrun},  32'h1);
    check("t2_no_accept",  q.size(),          32'd0);
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    $display("t2: accepted %0d byte(s)", q.size());
    check("t2_valid_clr",   {31'd0, rx_valid}, 32'h0);
    check("t2_overrun_clr", {31'd0, overrun},  32'h0);
    check("t2_acc_count",   q.size(),          32'd1);
    check("t2_acc_data",    q_at(0),           32'h3C);

    // 3: framing error, long break, then a good byte
    rx_ready = 1'b1;
    q.delete();
    fe_base = fe_cnt;
    valid_base = valid_cnt;
    send_byte(8'h55, 1'b0, BIT_CLK);
    wait_clk(20 * BIT_CLK);
    $display("t3: sent 0x55 bad stop, frame_err cycles=%0d", fe_cnt - fe_base);
    check("t3_fe_pulse",    fe_cnt - fe_base,       32'd1);
    check("t3_no_valid",    valid_cnt - valid_base, 32'd0);
    rx_in = 1'b1;
    wait_clk(2 * BIT_CLK);
    send_byte(8'h81, 1'b1, BIT_CLK);
    wait_clk(16);
    $display("t3: sent 0x81 after break, got %0d byte(s)", q.size());
    check("t3_count",       q.size(),         32'd1);
    check("t3_data",        q_at(0),          32'h81);
    check("t3_fe_no_more",  fe_cnt - fe_base, 32'd1);

    // 4: short low glitch is ignored
    q.delete();
    fe_base = fe_cnt;
    rx_in = 1'b0;
    wait_clk(12);
    rx_in = 1'b1;
    wait_clk(3 * BIT_CLK);
    $display("t4: 12-clk glitch, got %0d byte(s)", q.size());
    check("t4_glitch_none", q.size(),         32'd0);
    check("t4_glitch_fe",   fe_cnt - fe_base, 32'd0);
    send_byte(8'h00, 1'b1, BIT_CLK);
    wait_clk(16);
    $display("t4: sent 0x00, got %0d byte(s)", q.size());
    check("t4_count",       q.size(),         32'd1);
    check("t4_data",        q_at(0),          32'h00);

    // 6: bit period -3% and +3%
    q.delete();
    send_byte(8'h6E, 1'b1, 62);
    wait_clk(BIT_CLK);
    send_byte(8'h91, 1'b1, 66);
    wait_clk(16);
    $display("t6: sent 0x6E@62clk, 0x91@66clk, got %0d byte(s)", q.size());
    check("t6_count",  q.size(), 32'd2);
    check("t6_data0",  q_at(0),  32'h6E);
    check("t6_data1",  q_at(1),  32'h91);

    // 5: reset during data bit 4 of 0xF0, then 0x0F
    q.delete();
    fe_base = fe_cnt;
    rx_in = 1'b0;
    wait_clk(BIT_CLK);                 // start bit
    wait_clk(4 * BIT_CLK);             // bits 0..3 of 0xF0 are 0
    rx_in = 1'b1;                      // bit 4
    wait_clk(20);
    reset = 1'b0;
    wait_clk(3);
    $display("t5: in reset, rx_data=0x%0h rx_valid=%0b", rx_data, rx_valid);
    check("t5_rst_rx_data",   {24'd0, rx_data},   32'h00);
    check("t5_rst_rx_valid",  {31'd0, rx_valid},  32'h0);
    check("t5_rst_frame_err", {31'd0, frame_err}, 32'h0);
    check("t5_rst_overrun",   {31'd0, overrun},   32'h0);
    wait_clk(10);
    reset = 1'b1;
    wait_clk(31 + 3 * BIT_CLK + BIT_CLK);  // rest of bit 4, bits 5..7, stop
    send_byte(8'h0F, 1'b1, BIT_CLK);
    wait_clk(16);
    $display("t5: sent 0x0F after reset, got %0d byte(s)", q.size());
    check("t5_count", q.size(),         32'd1);
    check("t5_data",  q_at(0),          32'h0F);
    check("t5_fe",    fe_cnt - fe_base, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
